// File: rtl/processor_dp_pkg.sv
// Shared types for the lab-processor register-file datapath.
package processor_dp_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD   = 2'b00,
    MODE_ALU    = 2'b01,
    MODE_REPEAT = 2'b10,
    MODE_NOP    = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ADD   = 3'b000,
    SUB   = 3'b001,
    AND   = 3'b010,
    OR    = 3'b011,
    XOR   = 3'b100,
    NOT   = 3'b101,
    SHL   = 3'b110,
    PASSB = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_gen.sv
// Combinational ALU; result is mod 2^DATA_W, carry is 0 for logic ops and pass-B.
module alu_gen
  import processor_dp_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  input  alu_op_t           sel,
  output logic [DATA_W-1:0] f,
  output logic              c_out
);

  logic [DATA_W:0] a_ext, b_ext, c_ext, wide;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};
  assign c_ext = {{DATA_W{1'b0}}, c_in};

  // NOTE: every output gets a default first, so no path through the case leaves a latch.
  always_comb begin
    f     = '0;
    c_out = 1'b0;
    wide  = '0;
    case (sel)
      ADD: begin
        wide  = a_ext + b_ext + c_ext;
        f     = wide[DATA_W-1:0];
        c_out = wide[DATA_W];
      end
      SUB: begin
        // Bit DATA_W of the extended difference is set exactly when a < b + c_in.
        wide  = a_ext - b_ext - c_ext;
        f     = wide[DATA_W-1:0];
        c_out = wide[DATA_W];
      end
      AND:   f = a & b;
      OR:    f = a | b;
      XOR:   f = a ^ b;
      NOT:   f = ~a;
      SHL: begin
        f     = {a[DATA_W-2:0], 1'b0};
        c_out = a[DATA_W-1];
      end
      PASSB: f = b;
      default: f = '0;
    endcase
  end

endmodule

// File: rtl/btn_debounce.sv
// Button debouncer: a level change must persist for DB_COUNT+1 m_sec ticks;
// emits a one-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DB_SIZE  = 9,
  parameter int DB_COUNT = 499
) (
  input  logic clk,
  input  logic rst,
  input  logic m_sec,
  input  logic btn,
  output logic pulse
);

  localparam logic [DB_SIZE-1:0] THRESH = DB_SIZE'(DB_COUNT);

  logic [1:0]         sync_q;
  logic               stable_q;
  logic               stable_prev_q;
  logic [DB_SIZE-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q        <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync_q        <= {sync_q[0], btn};
      stable_prev_q <= stable_q;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (m_sec) begin
        if (cnt_q == THRESH) begin
          stable_q <= sync_q[1];
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign pulse = stable_q & ~stable_prev_q;

endmodule

// File: rtl/processor_dp_gen.sv
// Register-file datapath with sequenced ALU and repeat mode.
// Define PROC_DP_CARRY_CHAIN_EN to feed each repeat iteration's carry into the next.
module processor_dp_gen
  import processor_dp_pkg::*;
#(
  parameter  int DATA_W    = 4,
  parameter  int REG_COUNT = 16,
  parameter  int CNT_W     = 4,
  parameter  int DB_SIZE   = 9,
  parameter  int DB_COUNT  = 499,
  localparam int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_sec,
  input  logic              btn,
  input  logic [1:0]        mode,
  input  logic [2:0]        alu_sel,
  input  logic              c_in,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rp_addr,
  input  logic [ADDR_W-1:0] rq_addr,
  input  logic [DATA_W-1:0] imm,
  input  logic [CNT_W-1:0]  rep_cnt,
  output logic [DATA_W-1:0] rp_data,
  output logic [DATA_W-1:0] rq_data,
  output logic              c_out,
  output logic              busy,
  output logic              done
);

  logic start;

  btn_debounce #(.DB_SIZE(DB_SIZE), .DB_COUNT(DB_COUNT)) u_db (
    .clk   (clk),
    .rst   (rst),
    .m_sec (m_sec),
    .btn   (btn),
    .pulse (start)
  );

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    iter_q, iter_d;
  mode_t               mode_q;
  alu_op_t             sel_q;
  logic                cin_q;
  logic [ADDR_W-1:0]   wr_q, rp_q, rq_q;
  logic [DATA_W-1:0]   imm_q;
  logic                c_out_q;
  logic [DATA_W-1:0]   regs_q [REG_COUNT];

  logic                latch, reg_we, carry_we;
  logic [ADDR_W-1:0]   reg_waddr;
  logic [DATA_W-1:0]   reg_wdata;
  logic [DATA_W-1:0]   op_a, op_b, alu_f;
  logic                alu_c;

  assign op_a = regs_q[rp_q];
  assign op_b = regs_q[rq_q];

  alu_gen #(.DATA_W(DATA_W)) u_alu (
    .a     (op_a),
    .b     (op_b),
    .c_in  (cin_q),
    .sel   (sel_q),
    .f     (alu_f),
    .c_out (alu_c)
  );

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    latch     = 1'b0;
    reg_we    = 1'b0;
    carry_we  = 1'b0;
    reg_waddr = wr_q;
    reg_wdata = imm_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          iter_d  = rep_cnt;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = DONE;
        case (mode_q)
          MODE_LOAD: reg_we = 1'b1;
          MODE_ALU: begin
            reg_we    = 1'b1;
            reg_wdata = alu_f;
            carry_we  = 1'b1;
          end
          MODE_REPEAT: begin
            reg_we    = 1'b1;
            reg_waddr = rp_q;
            reg_wdata = alu_f;
            carry_we  = 1'b1;
            if (iter_q != '0) begin
              iter_d  = iter_q - 1'b1;
              state_d = EXEC;
            end
          end
          default: ;
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      iter_q  <= '0;
      mode_q  <= MODE_LOAD;
      sel_q   <= ADD;
      cin_q   <= 1'b0;
      wr_q    <= '0;
      rp_q    <= '0;
      rq_q    <= '0;
      imm_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      if (latch) begin
        mode_q <= mode_t'(mode);
        sel_q  <= alu_op_t'(alu_sel);
        cin_q  <= c_in;
        wr_q   <= wr_addr;
        rp_q   <= rp_addr;
        rq_q   <= rq_addr;
        imm_q  <= imm;
      end
      if (carry_we) begin
        c_out_q <= alu_c;
`ifdef PROC_DP_CARRY_CHAIN_EN
        if (mode_q == MODE_REPEAT) cin_q <= alu_c;
`endif
      end
    end
  end

  // NOTE: the register file must clear on reset, so it is built from resettable flops rather than RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[reg_waddr] <= reg_wdata;
    end
  end

  assign rp_data = regs_q[rp_addr];
  assign rq_data = regs_q[rq_addr];
  assign c_out   = c_out_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_processor_dp_gen.sv
// Directed self-checking bench for processor_dp_gen (short debounce threshold).
module tb_processor_dp_gen;

  logic       clk = 1'b0;
  logic       rst, m_sec, btn, c_in;
  logic [1:0] mode;
  logic [2:0] alu_sel;
  logic [3:0] wr_addr, rp_addr, rq_addr, imm, rep_cnt;
  logic [3:0] rp_data, rq_data;
  logic       c_out, busy, done;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  processor_dp_gen #(
    .DATA_W(4), .REG_COUNT(16), .CNT_W(4), .DB_SIZE(4), .DB_COUNT(2)
  ) dut (
    .clk(clk), .rst(rst), .m_sec(m_sec), .btn(btn), .mode(mode),
    .alu_sel(alu_sel), .c_in(c_in), .wr_addr(wr_addr), .rp_addr(rp_addr),
    .rq_addr(rq_addr), .imm(imm), .rep_cnt(rep_cnt), .rp_data(rp_data),
    .rq_data(rq_data), .c_out(c_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef PROC_DP_CARRY_CHAIN_EN
  localparam logic [3:0] CHAIN2_EXP = 4'h1;
`else
  localparam logic [3:0] CHAIN2_EXP = 4'h2;
`endif

  typedef struct {
    logic [2:0] s;
    logic [3:0] p;
    logic [3:0] q;
    logic       ci;
    logic [3:0] f;
    logic       c;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [3:0] v);
    rq_addr = a;
    #1;
    v = rq_data;
  endtask

  task automatic count_nonzero(input int skip, output int n);
    logic [3:0] v;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v);
      if (i != skip && v !== 4'h0) n++;
    end
  endtask

  task automatic run_cmd(input logic [1:0] m, input logic [2:0] s, input logic ci,
                         input logic [3:0] w, input logic [3:0] p, input logic [3:0] q,
                         input logic [3:0] im, input logic [3:0] rc,
                         output int bcyc, output int dpos);
    int n;
    mode = m; alu_sel = s; c_in = ci; wr_addr = w; rp_addr = p; rq_addr = q;
    imm = im; rep_cnt = rc;
    btn = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    check("busy_rise", busy, 1);
    bcyc = 0; dpos = 0; n = 0;
    while (busy === 1'b1 && n < 40) begin
      bcyc++;
      if (done === 1'b1) dpos = bcyc;
      @(negedge clk);
      n++;
    end
    btn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] v);
    int b, d;
    run_cmd(2'b00, 3'b000, 1'b0, a, 4'h0, 4'h0, v, 4'h0, b, d);
  endtask

  initial begin
    logic [3:0] v;
    int bc, dp, nz, d0;
    logic busy_seen;

    rst = 1'b0; m_sec = 1'b1; btn = 1'b0; c_in = 1'b0; mode = 2'b11;
    alu_sel = 3'b000; wr_addr = '0; rp_addr = '0; rq_addr = '0; imm = '0; rep_cnt = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cout", c_out, 0);
    check("rst_rp0", rp_data, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Load immediate
    run_cmd(2'b00, 3'b000, 1'b0, 4'd3, 4'd0, 4'd0, 4'd9, 4'd0, bc, dp);
    check("load_busy_cycles", bc, 2);
    check("load_done_pos", dp, 2);
    rp_addr = 4'd3; #1;
    check("load_r3", rp_data, 4'h9);
    count_nonzero(3, nz);
    check("load_others_zero", nz, 0);

    load(4'd1, 4'hF);
    load(4'd2, 4'h2);
    load(4'd5, 4'h1);
    load(4'd6, 4'h3);

    // ADD with carry in
    run_cmd(2'b01, 3'b000, 1'b1, 4'd4, 4'd1, 4'd2, 4'h0, 4'h0, bc, dp);
    rd(4'd4, v);
    check("add_r4", v, 4'h2);
    check("add_cout", c_out, 1);
    check("add_done_pos", dp, 2);

    vecs[0] = '{3'd1, 4'd2, 4'd1, 1'b0, 4'h3, 1'b1};
    vecs[1] = '{3'd1, 4'd1, 4'd2, 1'b1, 4'hC, 1'b0};
    vecs[2] = '{3'd2, 4'd1, 4'd2, 1'b0, 4'h2, 1'b0};
    vecs[3] = '{3'd3, 4'd2, 4'd5, 1'b0, 4'h3, 1'b0};
    vecs[4] = '{3'd4, 4'd1, 4'd2, 1'b0, 4'hD, 1'b0};
    vecs[5] = '{3'd5, 4'd2, 4'd0, 1'b0, 4'hD, 1'b0};
    vecs[6] = '{3'd6, 4'd1, 4'd0, 1'b0, 4'hE, 1'b1};
    vecs[7] = '{3'd6, 4'd6, 4'd0, 1'b0, 4'h6, 1'b0};
    vecs[8] = '{3'd7, 4'd1, 4'd6, 1'b0, 4'h3, 1'b0};
    vecs[9] = '{3'd0, 4'd6, 4'd5, 1'b1, 4'h5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      run_cmd(2'b01, vecs[i].s, vecs[i].ci, 4'd10, vecs[i].p, vecs[i].q, 4'h0, 4'h0, bc, dp);
      rd(4'd10, v);
      check($sformatf("alu%0d_f", i), v, vecs[i].f);
      check($sformatf("alu%0d_c", i), c_out, vecs[i].c);
    end

    // No-op leaves the register file alone
    run_cmd(2'b11, 3'b000, 1'b0, 4'd10, 4'd0, 4'd0, 4'hF, 4'h0, bc, dp);
    rd(4'd10, v);
    check("nop_r10", v, 4'h5);
    check("nop_busy_cycles", bc, 2);

    // Repeat accumulate: r5 = 1 + 4*3
    d0 = done_seen;
    run_cmd(2'b10, 3'b000, 1'b0, 4'd0, 4'd5, 4'd6, 4'h0, 4'd3, bc, dp);
    rd(4'd5, v);
    check("rep_r5", v, 4'hD);
    rd(4'd6, v);
    check("rep_r6", v, 4'h3);
    check("rep_busy_cycles", bc, 5);
    check("rep_done_pos", dp, 5);
    check("rep_done_count", done_seen - d0, 1);

    // Self-doubling with rq == rp
    load(4'd11, 4'h1);
    run_cmd(2'b10, 3'b000, 1'b0, 4'd0, 4'd11, 4'd11, 4'h0, 4'd2, bc, dp);
    rd(4'd11, v);
    check("dbl_r11", v, 4'h8);

    // Busy lockout: second press mid-repeat is dropped
    load(4'd8, 4'h1);
    d0 = done_seen;
    mode = 2'b10; alu_sel = 3'b000; c_in = 1'b0; rp_addr = 4'd7; rq_addr = 4'd8;
    wr_addr = 4'd0; rep_cnt = 4'd14; imm = 4'h0;
    btn = 1'b1;
    nz = 0;
    while (busy !== 1'b1 && nz < 30) begin @(negedge clk); nz++; end
    check("lock_busy_rise", busy, 1);
    btn = 1'b0; mode = 2'b00; wr_addr = 4'd9; imm = 4'h7;
    repeat (6) @(negedge clk);
    btn = 1'b1;
    repeat (7) @(negedge clk);
    check("lock_busy_window", busy, 1);
    nz = 0;
    while (busy === 1'b1 && nz < 40) begin @(negedge clk); nz++; end
    check("lock_busy_fall", busy, 0);
    repeat (3) @(negedge clk);
    check("lock_no_queue", busy, 0);
    check("lock_done_count", done_seen - d0, 1);
    rd(4'd9, v);
    check("lock_r9", v, 4'h0);
    rd(4'd7, v);
    check("lock_r7", v, 4'hF);
    btn = 1'b0;
    repeat (8) @(negedge clk);

    // Carry chain
    load(4'd0, 4'hF);
    load(4'd1, 4'h0);
    run_cmd(2'b10, 3'b000, 1'b1, 4'd0, 4'd0, 4'd1, 4'h0, 4'd1, bc, dp);
    rd(4'd0, v);
    check("chain1_r0", v, 4'h1);
    check("chain1_cout", c_out, 0);
    load(4'd0, 4'hF);
    run_cmd(2'b10, 3'b000, 1'b1, 4'd0, 4'd0, 4'd1, 4'h0, 4'd2, bc, dp);
    rd(4'd0, v);
    check("chain2_r0", v, CHAIN2_EXP);
    check("chain2_cout", c_out, 0);

    // Reset during the third EXEC cycle of a long repeat: r9 = 0+F, then F+F
    d0 = done_seen;
    mode = 2'b10; alu_sel = 3'b000; c_in = 1'b0; rp_addr = 4'd9; rq_addr = 4'd7;
    rep_cnt = 4'd15;
    btn = 1'b1;
    nz = 0;
    while (busy !== 1'b1 && nz < 30) begin @(negedge clk); nz++; end
    check("mid_busy_rise", busy, 1);
    repeat (2) @(negedge clk);
    check("mid_pre_cout", c_out, 1);
    rst = 1'b0;
    btn = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_cout", c_out, 0);
    count_nonzero(-1, nz);
    check("mid_regs_zero", nz, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    check("post_busy_never", busy_seen, 0);
    check("post_done_never", done_seen - d0, 0);
    count_nonzero(-1, nz);
    check("post_regs_zero", nz, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
